// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, matrix geometry and the lowest-zero column encoder.
package keypad_pkg;

  localparam int ROWS           = 4;
  localparam int COLS           = 4;
  localparam int DEB_CNT_DEF    = 1_000_000;
  localparam int SETTLE_CNT_DEF = 50;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    SCAN,
    REPORT,
    WAIT_REL
  } state_t;

  // Index of the lowest-numbered closed (low) column; 0 when none is low.
  function automatic logic [1:0] low_zero_idx(input logic [COLS-1:0] cols);
    low_zero_idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) low_zero_idx = i[1:0];
    end
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous inputs; output lags input by 2 sclk cycles.
// Resets to all-ones so idle pulled-up lines never look like a closed contact.
module key_sync #(
  parameter int W = 4
) (
  input  logic         sclk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: debounced press, row-by-row scan, one coded event per press.
// Event latency ~DEB_CNT + (row+1)*SETTLE_CNT + 1 cycles; no new event until release is debounced.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_CNT    = DEB_CNT_DEF,
  parameter int SETTLE_CNT = SETTLE_CNT_DEF,
  parameter int CNT_W      = $clog2(DEB_CNT)
) (
  input  logic            sclk,
  input  logic            nrst,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CNT - 1);

  logic [COLS-1:0] w_col_s;
  logic            w_hit;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]      r_row_idx;
  logic [ROWS-1:0] r_row_out;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;

  key_sync #(.W(COLS)) u_col_sync (
    .sclk (sclk),
    .nrst (nrst),
    .d    (col_in),
    .q    (w_col_s)
  );

  assign w_hit = (w_col_s != '1);

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_row_idx   <= 2'd0;
      r_row_out   <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_row_out <= '0;
          if (w_hit) r_state <= DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!w_hit) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt     <= '0;
            r_row_idx <= 2'd0;
            r_row_out <= 4'b1110;
            r_state   <= SCAN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SCAN: begin
          // Columns are only trusted once the row drive has settled through the synchronizer.
          if (r_cnt == SETTLE_LAST) begin
            r_cnt <= '0;
            if (w_hit) begin
              r_key_code  <= {r_row_idx, low_zero_idx(w_col_s)};
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_row_out   <= '0;
              r_state     <= REPORT;
            end else if (r_row_idx == 2'd3) begin
              r_row_out <= '0;
              r_state   <= IDLE;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
              r_row_out <= ~(4'b0001 << (r_row_idx + 2'd1));
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REPORT: begin
          r_cnt   <= '0;
          r_state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (w_hit) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt      <= '0;
            r_key_held <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_row_out <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign row_out   = r_row_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with DEB_CNT=100, SETTLE_CNT=4 and a behavioural key matrix.
module tb_keypad_scan_ctrl;

  logic       sclk;
  logic       nrst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int          vectors;
  int          miscompares;
  int          pulses;
  int          n;
  logic        ok;

  keypad_scan_ctrl #(
    .DEB_CNT    (100),
    .SETTLE_CNT (4)
  ) dut (
    .sclk      (sclk),
    .nrst      (nrst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // A closed key pulls its column low only while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(negedge sclk) if (key_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge sclk);
  endtask

  task automatic wait_valid(input int maxc, output int cnt);
    cnt = 0;
    do begin
      @(negedge sclk);
      cnt++;
    end while (key_valid !== 1'b1 && cnt < maxc);
  endtask

  task automatic wait_held_low(input int maxc, output int cnt);
    cnt = 0;
    do begin
      @(negedge sclk);
      cnt++;
    end while (key_held !== 1'b0 && cnt < maxc);
  endtask

  initial begin
    vectors = 0; miscompares = 0; pulses = 0;
    keys = 16'h0;
    nrst = 1'b0;
    tick(3);
    chk("rst_row_out", 32'(row_out), 0);
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_held", 32'(key_held), 0);
    nrst = 1'b1;
    tick(20);
    chk("idle_row_out", 32'(row_out), 0);

    // 1: clean press row2/col1, held 300 cycles.
    keys[9] = 1'b1;
    wait_valid(300, n);
    chk("t1_latency", 32'(n), 115);
    chk("t1_code", 32'(key_code), 9);
    tick(1);
    chk("t1_valid_one_cycle", 32'(key_valid), 0);
    chk("t1_held", 32'(key_held), 1);
    chk("t1_rows_released", 32'(row_out), 0);
    tick(184);
    chk("t1_held_at_300", 32'(key_held), 1);
    keys = 16'h0;
    wait_held_low(300, n);
    chk("t1_release_deb", 32'(n), 102);
    chk("t1_pulses", 32'(pulses), 1);
    tick(10);

    // 2: 50-cycle press bounce must be rejected.
    ok = 1'b1;
    keys[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sclk);
      if (row_out !== 4'b0000 || key_held !== 1'b0) ok = 1'b0;
    end
    keys = 16'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sclk);
      if (row_out !== 4'b0000 || key_held !== 1'b0) ok = 1'b0;
    end
    chk("t2_rows_idle", 32'(ok), 1);
    chk("t2_no_event", 32'(pulses), 1);

    // 3: row1/col3 and row2/col0 together; row 1 wins.
    keys[7] = 1'b1;
    keys[8] = 1'b1;
    wait_valid(300, n);
    chk("t3_latency", 32'(n), 111);
    chk("t3_code", 32'(key_code), 7);
    tick(20);
    keys = 16'h0;
    wait_held_low(300, n);
    chk("t3_release_deb", 32'(n), 102);
    chk("t3_pulses", 32'(pulses), 2);
    tick(10);

    // 4: release glitch restarts the release debounce.
    keys[14] = 1'b1;
    wait_valid(300, n);
    chk("t4_latency", 32'(n), 119);
    chk("t4_code", 32'(key_code), 14);
    tick(20);
    keys = 16'h0;
    tick(60);
    keys[14] = 1'b1;
    tick(5);
    keys = 16'h0;
    wait_held_low(300, n);
    chk("t4_glitch_deb", 32'(n), 102);
    chk("t4_pulses", 32'(pulses), 3);
    tick(10);

    // 5: key released during scan, before row 1 is sampled.
    keys[6] = 1'b1;
    tick(103);
    chk("t5_scan_row0", 32'(row_out), 4'b1110);
    keys = 16'h0;
    tick(4);
    chk("t5_scan_row1", 32'(row_out), 4'b1101);
    tick(40);
    chk("t5_rows_idle", 32'(row_out), 0);
    chk("t5_held", 32'(key_held), 0);
    chk("t5_code_kept", 32'(key_code), 14);
    chk("t5_no_event", 32'(pulses), 3);

    // 6: reset while row 2 is being driven.
    keys[15] = 1'b1;
    tick(111);
    chk("t6_scan_row2", 32'(row_out), 4'b1011);
    nrst = 1'b0;
    #1;
    chk("t6_rst_row_out", 32'(row_out), 0);
    chk("t6_rst_valid", 32'(key_valid), 0);
    chk("t6_rst_held", 32'(key_held), 0);
    chk("t6_rst_code", 32'(key_code), 0);
    keys = 16'h0;
    tick(3);
    nrst = 1'b1;
    tick(200);
    chk("t6_no_event", 32'(pulses), 3);
    chk("t6_code_after", 32'(key_code), 0);
    chk("t6_rows_idle", 32'(row_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 matrix keypad. Rows are driven active-low and the pull-up column inputs are read. A single shared timer debounces both press and release, and each debounced press produces one coded key event. It sits between the board keypad pins and user logic as the multi-key counterpart of the single-key debounce block, and it uses the same 20 ms / 50 MHz debounce convention.

Parameters:
DEB_CNT, 1_000_000, debounce window in sclk cycles (20 ms at 50 MHz); must be >= 2.
SETTLE_CNT, 50, cycles to wait after a row change before sampling columns (1 us at 50 MHz); must be >= 3 to cover synchronizer latency.
CNT_W, $clog2(DEB_CNT), shared counter width; must also hold SETTLE_CNT-1.

Ports:
sclk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
col_in  input  4  keypad columns, asynchronous, pulled up, low = key closed on a driven row
row_out  output  4  keypad row drive, active-low
key_code  output  4  code of the last reported key = row*4 + col
key_valid  output  1  one-cycle pulse when key_code is updated
key_held  output  1  high from report until release is debounced

Behaviour:
- Reset is nrst, asynchronous, active-low; the clock is sclk. All state is reset asynchronously.
- Reset values:
  - row_out = 4'b0000
  - key_code = 0, key_valid = 0, key_held = 0
  - state = IDLE, counter = 0, row_idx = 0
  - synchronizer flops = 4'hF
- col_in passes through a 2-flop synchronizer to give col_s. All decisions below use col_s only.
- FSM states: IDLE, DEB_PRESS, SCAN, REPORT, WAIT_REL.
- IDLE:
  - row_out = 0000, counter held at 0.
  - If col_s != 4'hF, go to DEB_PRESS.
- DEB_PRESS:
  - row_out = 0000.
  - If col_s == 4'hF, clear the counter and go back to IDLE (bounce rejected).
  - Otherwise increment the counter.
  - When the counter == DEB_CNT-1 while still pressed, go to SCAN with row_idx = 0 and counter = 0.
- SCAN:
  - row_out = ~(4'b0001 << row_idx).
  - The counter runs 0..SETTLE_CNT-1. At counter == SETTLE_CNT-1, sample col_s:
    - If col_s != F: latch key_code = {row_idx, index of the lowest-numbered zero bit of col_s} and go to REPORT.
    - Else if row_idx == 3: go to IDLE (key released during scan; no event).
    - Else: row_idx + 1, counter = 0, stay in SCAN.
  - Rows are scanned in the order 0..3 and columns are priority-encoded lowest-first. The first hit wins; other simultaneous keys are ignored.
- REPORT:
  - Lasts one cycle.
  - key_valid = 1 for exactly this cycle, registered together with key_code.
  - row_out returns to 0000 and the counter is cleared. Go to WAIT_REL.
- WAIT_REL:
  - row_out = 0000.
  - If col_s != F, counter = 0; otherwise the counter increments.
  - When the counter == DEB_CNT-1, go to IDLE.
  - No new event is possible until release has been stable for DEB_CNT cycles.
- key_held is 1 from the cycle key_valid asserts until the cycle WAIT_REL exits, inclusive. It is 0 in every other state.
- key_code holds its value between events.
- Latency, counted from the first synchronized low column cycle of a clean press to key_valid: DEB_CNT + (row+1)*SETTLE_CNT + 1 cycles, ±1.
- Counter wrap-around is impossible by construction; it never exceeds DEB_CNT-1.
- Reset mid-operation: all outputs return to reset values immediately. No partial event is emitted after reset release.

Decomposition:
- Shared package keypad_pkg:
  - state enum (IDLE, DEB_PRESS, SCAN, REPORT, WAIT_REL)
  - ROWS = 4, COLS = 4
  - default DEB_CNT / SETTLE_CNT constants
- One sub-module: key_sync, a parameterised-width 2-flop synchronizer with reset value all-ones, used for col_in.
- The FSM, counter and priority encoder stay in keypad_scan_ctrl.

Test Plan:
All scenarios use DEB_CNT = 100 and SETTLE_CNT = 4.
1. Clean press of the key at row 2, col 1 (col_in[1] low only while row_out[2] = 0), held 300 cycles then released -> exactly one key_valid pulse with key_code = 9; key_held high until 100 clean released cycles have passed.
2. Press bounce: col_in[0] low 50 cycles then high -> no key_valid; FSM returns to IDLE; row_out stays 0000.
3. Keys row1/col3 and row2/col0 pressed together -> single event with key_code = 7.
4. Release bounce: after a report, release, then a 5-cycle low glitch at release+60 -> IDLE is reached 100 cycles after the glitch ends; no second key_valid.
5. Press debounced, then released before row 1 is sampled during SCAN -> all rows sampled high, return to IDLE, no key_valid, key_code unchanged.
6. nrst asserted mid-SCAN (row_out = 1011) -> row_out = 0000, key_valid/key_held = 0, key_code = 0 immediately; after release with keys idle, no spurious event.
